if_stage: RTL

//  Instruction-fetch stage of the 5-stage RV32 pipeline. Owns the PC, drives the

---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/if_stage_ifid_reg.sv | 37 +++
 rtl/if_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID register.
//   XLEN            datapath width
//   NOP_INST_DEF    bubble written into IF/ID (addi x0,x0,0)
//   RESET_PC_DEF    default PC after reset
//   ifid_t          contents of the IF/ID pipeline register
//   align_word()    clears the byte-offset bits of an address
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register with reset, flush and hold controls.
// Ports:
//   clk    clock, all state on rising edge
//   rst    synchronous active-high reset
//   hold   keep current contents
//   flush  replace instruction with a bubble; pc/pc4 keep their values
//   d      next contents when neither hold nor flush
//   q      registered contents
// Priority: rst > flush > hold > load.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INST_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q.inst  <= NOP;
      q.pc    <= '0;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.inst  <= NOP;
      q.valid <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and loads the fetched word into IF/ID.
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   stall        hold PC and IF/ID
//   redirect     taken branch/jump from EX; flushes IF/ID
//   redirect_pc  redirect target (low two bits dropped)
//   imem_addr    word address = pc[IMEM_AW+1:2]
//   imem_data    instruction word returned for imem_addr
//   ifid_inst    registered instruction
//   ifid_pc      registered PC of ifid_inst
//   ifid_pc4     registered ifid_pc + 4
//   ifid_valid   ifid_inst is a real fetched instruction
//   misalign     sticky flag: some redirect target was not word aligned
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              IMEM_AW  = 6,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  output logic [XLEN-1:0]    ifid_inst,
  output logic [XLEN-1:0]    ifid_pc,
  output logic [XLEN-1:0]    ifid_pc4,
  output logic               ifid_valid,
  output logic               misalign
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;
  ifid_t           ifid_d;
  ifid_t           ifid_q;

  assign pc_plus4  = pc + 32'd4;
  // Upper PC bits are ignored, so fetch wraps modulo the memory size.
  assign imem_addr = pc[IMEM_AW+1:2];

  // Redirect beats stall: a taken branch must discard the stalled fetch.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect) begin
      pc_next = align_word(redirect_pc);
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= align_word(RESET_PC);
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end

  assign ifid_d = '{inst: imem_data, pc: pc, pc4: pc_plus4, valid: 1'b1};

  ifid_reg #(
    .NOP (NOP_INST)
  ) u_ifid_reg (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .flush (redirect),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ifid_inst  = ifid_q.inst;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = ifid_q.valid;

endmodule
